// File: rtl/mema_row_sequencer.sv
// Row sequencer for the coefficient memory: fetches one row per cluster and
// streams its elements one at a time over a valid/ready handshake.
module mema_row_sequencer #(
  parameter int number_of_clusters              = 1,
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width                   = 64,
  parameter int address_width                   = 20,
  localparam int ELEMS = 3 * number_of_equations_per_cluster - 2,
  localparam int IDXW  = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  output logic [address_width-1:0]         mem_address,
  input  logic [element_width*ELEMS-1:0]   mem_row,
  output logic [element_width-1:0]         elem_data,
  output logic                             elem_valid,
  input  logic                             elem_ready,
  output logic [IDXW-1:0]                  elem_index,
  output logic [address_width-1:0]         cluster_index,
  output logic                             last_element,
  output logic                             busy,
  output logic                             done
);

  localparam logic [IDXW-1:0]          LAST_ELEM    = IDXW'(ELEMS - 1);
  localparam logic [address_width-1:0] LAST_CLUSTER = address_width'(number_of_clusters - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [address_width-1:0]   memAddress_q, memAddress_d;
  logic [address_width-1:0]   clusterIndex_q, clusterIndex_d;
  logic [IDXW-1:0]            elemIndex_q, elemIndex_d;
  logic [element_width*ELEMS-1:0] rowReg_q, rowReg_d;

  // Next-state logic: abort always wins, and the last element of a row either
  // advances to the next row's fetch or closes the pass.
  always_comb begin
    state_d        = state_q;
    memAddress_d   = memAddress_q;
    clusterIndex_d = clusterIndex_q;
    elemIndex_d    = elemIndex_q;
    rowReg_d       = rowReg_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d        = FETCH;
          memAddress_d   = '0;
          clusterIndex_d = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d      = IDLE;
          memAddress_d = '0;
        end else begin
          rowReg_d    = mem_row;
          elemIndex_d = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d      = IDLE;
          memAddress_d = '0;
        end else if (elem_ready) begin
          if (elemIndex_q == LAST_ELEM) begin
            elemIndex_d = '0;
            if (clusterIndex_q == LAST_CLUSTER) begin
              state_d      = DONE;
              memAddress_d = '0;
            end else begin
              state_d        = FETCH;
              clusterIndex_d = clusterIndex_q + address_width'(1);
              memAddress_d   = memAddress_q + address_width'(1);
            end
          end else begin
            elemIndex_d = elemIndex_q + IDXW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so all outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      memAddress_q   <= '0;
      clusterIndex_q <= '0;
      elemIndex_q    <= '0;
      rowReg_q       <= '0;
    end else begin
      state_q        <= state_d;
      memAddress_q   <= memAddress_d;
      clusterIndex_q <= clusterIndex_d;
      elemIndex_q    <= elemIndex_d;
      rowReg_q       <= rowReg_d;
    end
  end

  // Element selection from the held row; element 0 sits in the LSBs.
  always_comb begin
    elem_data = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (elemIndex_q == IDXW'(i)) begin
        elem_data = rowReg_q[i*element_width +: element_width];
      end
    end
  end

  assign mem_address   = memAddress_q;
  assign elem_index    = elemIndex_q;
  assign cluster_index = clusterIndex_q;
  assign elem_valid    = (state_q == STREAM);
  assign busy          = (state_q == FETCH) || (state_q == STREAM);
  assign done          = (state_q == DONE) && !abort;
  assign last_element  = elem_valid && (elemIndex_q == LAST_ELEM) &&
                         (clusterIndex_q == LAST_CLUSTER);

endmodule

// File: tb/tb_mema_row_sequencer.sv
// Bench for mema_row_sequencer: a transfer-count model checked every cycle
// plus directed passes with literal expected element sequences.
module tb_mema_row_sequencer;

  localparam int EW    = 8;
  localparam int NEQ   = 2;
  localparam int ELEMS = 4;
  localparam int NC    = 3;
  localparam int AW    = 20;
  localparam int IDXW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, elem_ready = 1'b0;
  logic [AW-1:0]       mem_address, cluster_index;
  logic [EW*ELEMS-1:0] mem_row;
  logic [EW-1:0]       elem_data;
  logic [IDXW-1:0]     elem_index;
  logic                elem_valid, last_element, busy, done;

  logic start1 = 1'b0, elem_ready1 = 1'b1;
  logic [AW-1:0]       mem_address1, cluster_index1;
  logic [EW*ELEMS-1:0] mem_row1;
  logic [EW-1:0]       elem_data1;
  logic [IDXW-1:0]     elem_index1;
  logic                elem_valid1, last_element1, busy1, done1;

  mema_row_sequencer #(
    .number_of_clusters(NC), .number_of_equations_per_cluster(NEQ),
    .element_width(EW), .address_width(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_address(mem_address), .mem_row(mem_row), .elem_data(elem_data),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_index(elem_index),
    .cluster_index(cluster_index), .last_element(last_element), .busy(busy), .done(done)
  );

  mema_row_sequencer #(
    .number_of_clusters(1), .number_of_equations_per_cluster(NEQ),
    .element_width(EW), .address_width(AW)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .mem_address(mem_address1), .mem_row(mem_row1), .elem_data(elem_data1),
    .elem_valid(elem_valid1), .elem_ready(elem_ready1), .elem_index(elem_index1),
    .cluster_index(cluster_index1), .last_element(last_element1), .busy(busy1), .done(done1)
  );

  // Row r holds bytes {r3,r2,r1,r0}.
  function automatic logic [EW*ELEMS-1:0] rowOf(input logic [AW-1:0] r);
    logic [EW*ELEMS-1:0] v;
    v = '0;
    for (int k = 0; k < ELEMS; k++) v[k*EW +: EW] = {r[3:0], 4'(k)};
    return v;
  endfunction

  assign mem_row  = rowOf(mem_address);
  assign mem_row1 = rowOf(mem_address1);

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pass is NC*ELEMS accepted transfers with a one-cycle fetch bubble
  // before every row, followed by a one-cycle done.
  bit inPass  = 1'b0;
  bit bubble  = 1'b0;
  bit doneNow = 1'b0;
  int xfers   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inPass  <= 1'b0;
      bubble  <= 1'b0;
      doneNow <= 1'b0;
      xfers   <= 0;
    end else if (doneNow) begin
      doneNow <= 1'b0;
    end else if (!inPass) begin
      if (start && !abort) begin
        inPass <= 1'b1;
        bubble <= 1'b1;
        xfers  <= 0;
      end
    end else if (abort) begin
      inPass <= 1'b0;
      bubble <= 1'b0;
    end else if (bubble) begin
      bubble <= 1'b0;
    end else if (elem_ready) begin
      xfers <= xfers + 1;
      if (xfers + 1 == NC * ELEMS) begin
        inPass  <= 1'b0;
        doneNow <= 1'b1;
      end else if ((xfers + 1) % ELEMS == 0) begin
        bubble <= 1'b1;
      end
    end
  end

  // Per-cycle comparison plus bookkeeping of accepted elements and timing.
  logic [EW-1:0] accepted[$];
  int  cyc = 0, doneCount = 0, lastCount = 0;
  int  busyRiseCyc = 0, firstValidCyc = -1, doneCyc = 0;
  bit  prevBusy = 1'b0;
  logic [EW-1:0] lastVal = '0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit expValid;
        int row, idx;
        cyc++;
        expValid = inPass && !bubble;
        row = xfers / ELEMS;
        idx = xfers % ELEMS;
        checkOutput("elem_valid", 64'(elem_valid), 64'(expValid));
        checkOutput("busy", 64'(busy), 64'(inPass));
        checkOutput("done", 64'(done), 64'(doneNow && !abort));
        checkOutput("last_element", 64'(last_element), 64'(expValid && (xfers == NC*ELEMS-1)));
        checkOutput("mem_address", 64'(mem_address), inPass ? 64'(row) : 64'(0));
        if (expValid) begin
          checkOutput("elem_data", 64'(elem_data), 64'(row * 16 + idx));
          checkOutput("elem_index", 64'(elem_index), 64'(idx));
          checkOutput("cluster_index", 64'(cluster_index), 64'(row));
        end
        if (done) begin
          doneCount++;
          doneCyc = cyc;
        end
        if (busy && !prevBusy) begin
          busyRiseCyc   = cyc;
          firstValidCyc = -1;
        end
        prevBusy = busy;
        if (elem_valid && firstValidCyc < 0) firstValidCyc = cyc;
        if (elem_valid && elem_ready && !abort && rst_n) begin
          accepted.push_back(elem_data);
          if (last_element) begin
            lastCount++;
            lastVal = elem_data;
          end
        end
      end
    end
  end

  // One cycle of stimulus: drive just after a rising edge, hold across the next.
  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start      = s;
    abort      = a;
    elem_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilDone(input bit keepStart, input bit toggle);
    for (int c = 0; c < 60; c++) begin
      if (done) break;
      applyStimulus(keepStart, 1'b0, toggle ? logic'(c % 2 == 0) : 1'b1);
    end
    checkOutput("done reached", 64'(done), 64'(1));
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkSeq(input string tag);
    logic [EW-1:0] expSeq [12];
    expSeq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
               8'h20, 8'h21, 8'h22, 8'h23};
    checkOutput({tag, " xfer count"}, 64'(accepted.size()), 64'(12));
    for (int i = 0; i < accepted.size() && i < 12; i++)
      checkOutput($sformatf("%s xfer %0d", tag, i), 64'(accepted[i]), 64'(expSeq[i]));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " mem_address"}, 64'(mem_address), 64'(0));
    checkOutput({tag, " elem_data"}, 64'(elem_data), 64'(0));
    checkOutput({tag, " elem_index"}, 64'(elem_index), 64'(0));
    checkOutput({tag, " cluster_index"}, 64'(cluster_index), 64'(0));
    checkOutput({tag, " elem_valid"}, 64'(elem_valid), 64'(0));
    checkOutput({tag, " last_element"}, 64'(last_element), 64'(0));
    checkOutput({tag, " busy"}, 64'(busy), 64'(0));
    checkOutput({tag, " done"}, 64'(done), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0, l0, cnt, lc1;
    logic [EW-1:0] xf1[$];
    logic [EW-1:0] lv1;

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] full pass, ready held high");
    accepted.delete();
    d0 = doneCount;
    l0 = lastCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b0);
    checkSeq("pass1");
    checkOutput("pass1 done pulses", 64'(doneCount - d0), 64'(1));
    checkOutput("pass1 last count", 64'(lastCount - l0), 64'(1));
    checkOutput("pass1 last value", 64'(lastVal), 64'(8'h23));
    checkOutput("pass1 cycles fetch to done", 64'(doneCyc - busyRiseCyc), 64'(15));
    checkOutput("pass1 first valid latency", 64'(firstValidCyc - busyRiseCyc), 64'(1));

    $display("[TB] full pass, ready toggling");
    accepted.delete();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b1);
    checkSeq("toggle");
    checkOutput("toggle done pulses", 64'(doneCount - d0), 64'(1));

    $display("[TB] abort during row 1");
    accepted.delete();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (elem_valid && cluster_index == 1 && elem_index == 2) break;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("abort point reached",
                64'(elem_valid && cluster_index == 1 && elem_index == 2), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("valid after abort", 64'(elem_valid), 64'(0));
    checkOutput("busy after abort", 64'(busy), 64'(0));
    checkOutput("xfers kept before abort", 64'(accepted.size()), 64'(6));
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("no done after abort", 64'(doneCount - d0), 64'(0));
    accepted.delete();
    applyStimulus(1'b1, 1'b0, 1'b1);
    runUntilDone(1'b0, 1'b0);
    checkSeq("restart");

    $display("[TB] start held during stream");
    accepted.delete();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runUntilDone(1'b1, 1'b0);
    checkSeq("startheld");
    checkOutput("startheld done pulses", 64'(doneCount - d0), 64'(1));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle after pass", 64'(busy), 64'(0));

    $display("[TB] reset during fetch of row 2");
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (busy && !elem_valid && mem_address == 2) break;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("row2 fetch reached", 64'(busy && !elem_valid && mem_address == 2), 64'(1));
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle after reset release", 64'(busy), 64'(0));
    checkOutput("no done after reset", 64'(doneCount - d0), 64'(0));

    $display("[TB] single-cluster instance");
    lc1 = 0;
    lv1 = '0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done1) break;
      checkOutput("nc1 mem_address", 64'(mem_address1), 64'(0));
      if (elem_valid1) begin
        xf1.push_back(elem_data1);
        if (last_element1) begin
          lc1++;
          lv1 = elem_data1;
        end
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("nc1 done reached", 64'(done1), 64'(1));
    checkOutput("nc1 cycles fetch to done", 64'(cnt), 64'(5));
    checkOutput("nc1 xfer count", 64'(xf1.size()), 64'(4));
    for (int i = 0; i < xf1.size() && i < 4; i++)
      checkOutput($sformatf("nc1 xfer %0d", i), 64'(xf1[i]), 64'(i));
    checkOutput("nc1 last count", 64'(lc1), 64'(1));
    checkOutput("nc1 last value", 64'(lv1), 64'(8'h03));
    @(posedge clk);
    #1;
    checkOutput("nc1 done one cycle", 64'(done1), 64'(0));
    checkOutput("nc1 idle", 64'(busy1), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mema_row_sequencer.md
MEMA_ROW_SEQUENCER -- requirements
Module: mema_row_sequencer

Interface
REQ-001 Parameter: number_of_clusters, 1, number of rows held in the coefficient memory.
REQ-002 Parameter: number_of_equations_per_cluster, 9, equations per cluster; the block SHALL derive ELEMS = 3*number_of_equations_per_cluster-2 elements per row.
REQ-003 Parameter: element_width, 64, bits per element.
REQ-004 Parameter: address_width, 20, memory address width.
REQ-005 Parameter: IDXW = max(1,ceil(log2(ELEMS))), derived, element index width.
REQ-006 Port: clk  in  1  single clock, all state on rising edge.
REQ-007 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port: start  in  1  request a full pass over all rows.
REQ-009 Port: abort  in  1  terminate the current pass.
REQ-010 Port: mem_address  out  address_width  registered row address to the coefficient memory.
REQ-011 Port: mem_row  in  element_width*ELEMS  row data returned combinationally for mem_address.
REQ-012 Port: elem_data  out  element_width  current streamed element.
REQ-013 Port: elem_valid  out  1  elem_data valid.
REQ-014 Port: elem_ready  in  1  consumer accepts elem_data.
REQ-015 Port: elem_index  out  IDXW  index of current element within its row.
REQ-016 Port: cluster_index  out  address_width  row of current element.
REQ-017 Port: last_element  out  1  current element is the final element of the final row.
REQ-018 Port: busy  out  1  high in FETCH and STREAM.
REQ-019 Port: done  out  1  one-cycle pulse on pass completion.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, STREAM, DONE.
REQ-021 IDLE: start=1 and abort=0 -> FETCH; mem_address<=0; cluster_index<=0.
REQ-022 FETCH lasts exactly one cycle; at its closing edge row_reg<=mem_row, elem_index<=0, state->STREAM.
REQ-023 STREAM: elem_valid=1; elem_data = row_reg[elem_index*element_width +: element_width] (element 0 = LSBs).
REQ-024 A transfer occurs on an edge where elem_valid=1 and elem_ready=1; elem_index SHALL then increment.
REQ-025 While elem_valid=1 and elem_ready=0, elem_data, elem_index, cluster_index SHALL hold stable.
REQ-026 Transfer with elem_index=ELEMS-1 and cluster_index<number_of_clusters-1: cluster_index and mem_address increment, state->FETCH.
REQ-027 Transfer with elem_index=ELEMS-1 and cluster_index=number_of_clusters-1: state->DONE.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; mem_address returns to 0.
REQ-029 last_element = elem_valid AND elem_index=ELEMS-1 AND cluster_index=number_of_clusters-1.
REQ-030 Latency: start sampled at edge E0 -> first elem_valid after E0+1; one bubble cycle (FETCH) between rows.
REQ-031 With elem_ready held 1, a pass SHALL take number_of_clusters*(ELEMS+1) cycles from FETCH entry to DONE entry.
REQ-032 start while not IDLE SHALL be ignored.
REQ-033 abort=1 in FETCH/STREAM/DONE -> IDLE at next edge, no done pulse, elem_valid low; abort wins over a simultaneous transfer, which the consumer SHALL treat as discarded.
REQ-034 abort and start together in IDLE: remain IDLE.
REQ-035 number_of_clusters=1 SHALL be supported (single FETCH, no address increment).

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE; mem_address, elem_data, elem_index, cluster_index, row_reg=0; elem_valid, last_element, busy, done=0.
REQ-037 Reset asserted mid-pass SHALL discard the pass; after release the block waits for a new start.

Verification (element_width=8, number_of_equations_per_cluster=2 -> ELEMS=4, number_of_clusters=3; row r holds bytes {r3,r2,r1,r0}=0x{r}3{r}2{r}1{r}0)
REQ-038 start pulse, elem_ready=1 -> 12 transfers 0x00,0x01,0x02,0x03,0x10..0x13,0x20..0x23; done one cycle after last; last_element only on 0x23.
REQ-039 elem_ready toggled 1,0 per cycle -> same 12-value order, no duplicates/drops; values stable during stalls.
REQ-040 abort during row 1, elem_index=2 -> elem_valid low next cycle, no done; new start restarts at 0x00.
REQ-041 start during STREAM -> ignored; exactly 12 transfers, one done.
REQ-042 rst_n low during FETCH of row 2 -> all outputs 0 asynchronously; IDLE after release.
REQ-043 number_of_clusters=1, elem_ready=1 -> 4 transfers, mem_address constant 0, done after 5 cycles from FETCH entry.
